// File: rtl/enable_div_gen.sv
// Programmable clock-enable divider with continuous and one-shot run modes.
// Optional square-wave output o_sq when ENABLE_DIV_GEN_SQUARE_EN is defined.
module enable_div_gen #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned DEFAULT_DIV = 10
) (
   input  logic             clk,
   input  logic             i_arst,
   input  logic             i_sclr,
   input  logic             i_run,
   input  logic             i_mode,
   input  logic             i_div_load,
   input  logic [WIDTH-1:0] i_div,
   output logic             o_en,
   output logic [WIDTH-1:0] o_cnt,
   output logic             o_busy,
`ifdef ENABLE_DIV_GEN_SQUARE_EN
   output logic             o_sq,
`endif
   output logic [WIDTH-1:0] o_div
);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   localparam logic [WIDTH-1:0] DefDiv = WIDTH'(DEFAULT_DIV);
   localparam logic [WIDTH-1:0] One    = WIDTH'(1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] div_act_q, div_act_d;
   logic [WIDTH-1:0] div_pend_q, div_pend_d;
   logic             run_prev_q, run_prev_d;
   logic             mode_q, mode_d;

   logic [WIDTH-1:0] div_last;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] pend_fwd;
   logic             at_end;
   logic             tick;
   logic             run_rise;

   // Active divisor is never zero: a zero request is stored as 1.
   assign div_last = div_act_q - One;
   assign at_end   = (cnt_q >= div_last);
   assign tick     = (state_q == StRun) && (cnt_q == div_last);
   assign load_val = (i_div == '0) ? One : i_div;
   assign pend_fwd = i_div_load ? load_val : div_pend_q;
   assign run_rise = i_run & ~run_prev_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      div_act_d  = div_act_q;
      div_pend_d = pend_fwd;
      mode_d     = mode_q;
      run_prev_d = i_run;
      if (i_sclr) begin
         state_d    = StIdle;
         cnt_d      = '0;
         div_act_d  = div_pend_q;
         div_pend_d = div_pend_q;
         run_prev_d = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               // Mode is only latched here; a pending divisor takes effect at once.
               div_act_d = pend_fwd;
               mode_d    = i_mode;
               if (!i_mode && i_run) begin
                  state_d = StRun;
               end else if (i_mode && run_rise) begin
                  state_d = StRun;
                  cnt_d   = '0;
               end
            end
            StRun: begin
               // at_end also catches a count stranded above a shrunken divisor.
               if (at_end) begin
                  cnt_d     = '0;
                  div_act_d = pend_fwd;
               end else begin
                  cnt_d = cnt_q + One;
               end
               if (!mode_q && !i_run) begin
                  state_d = StIdle;
               end else if (mode_q && tick) begin
                  state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or posedge i_arst) begin
      if (i_arst) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         div_act_q  <= DefDiv;
         div_pend_q <= DefDiv;
         run_prev_q <= 1'b0;
         mode_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         div_act_q  <= div_act_d;
         div_pend_q <= div_pend_d;
         run_prev_q <= run_prev_d;
         mode_q     <= mode_d;
      end
   end

`ifdef ENABLE_DIV_GEN_SQUARE_EN
   logic sq_q, sq_d;

   always_comb begin
      sq_d = sq_q ^ tick;
      if (i_sclr) begin
         sq_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge i_arst) begin
      if (i_arst) begin
         sq_q <= 1'b0;
      end else begin
         sq_q <= sq_d;
      end
   end

   assign o_sq = sq_q;
`endif

   assign o_en   = tick;
   assign o_cnt  = cnt_q;
   assign o_busy = (state_q == StRun);
   assign o_div  = div_act_q;

endmodule

// File: tb/tb_enable_div_gen.sv
// Self-checking bench for enable_div_gen: vector table, directed corner sequences
// and a randomized run against a cycle-level reference model.
module tb_enable_div_gen;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         i_arst = 1'b1;
   logic         i_sclr = 1'b0;
   logic         i_run = 1'b0;
   logic         i_mode = 1'b0;
   logic         i_div_load = 1'b0;
   logic [W-1:0] i_div = '0;
   logic         o_en;
   logic [W-1:0] o_cnt;
   logic         o_busy;
   logic [W-1:0] o_div;
`ifdef ENABLE_DIV_GEN_SQUARE_EN
   logic         o_sq;
`endif

   enable_div_gen #(.WIDTH(W), .DEFAULT_DIV(10)) dut (
      .clk        (clk),
      .i_arst     (i_arst),
      .i_sclr     (i_sclr),
      .i_run      (i_run),
      .i_mode     (i_mode),
      .i_div_load (i_div_load),
      .i_div      (i_div),
      .o_en       (o_en),
      .o_cnt      (o_cnt),
      .o_busy     (o_busy),
`ifdef ENABLE_DIV_GEN_SQUARE_EN
      .o_sq       (o_sq),
`endif
      .o_div      (o_div)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state: plain integers describing the observable behaviour.
   int m_busy, m_cnt, m_act, m_pend, m_prev, m_mode, m_sq;
   int last_en, last_cnt;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int m_en();
      return (m_busy != 0 && m_cnt == m_act - 1) ? 1 : 0;
   endfunction

   task automatic model_reset();
      m_busy = 0; m_cnt = 0; m_act = 10; m_pend = 10; m_prev = 0; m_mode = 0; m_sq = 0;
   endtask

   task automatic model_step();
      int en, pnew;
      if (i_sclr) begin
         m_busy = 0; m_cnt = 0; m_act = m_pend; m_prev = 0; m_sq = 0;
         return;
      end
      en   = m_en();
      pnew = i_div_load ? ((i_div == 0) ? 1 : int'(i_div)) : m_pend;
      if (m_busy != 0) begin
         if (m_cnt >= m_act) m_cnt = 0;            // stranded above new divisor
         else m_cnt = (m_cnt + 1) % m_act;
         if (m_cnt == 0) m_act = pnew;              // period boundary
         if (m_mode == 0 && !i_run) m_busy = 0;
         if (m_mode == 1 && en == 1) m_busy = 0;
      end else begin
         m_act  = pnew;
         m_mode = int'(i_mode);
         if (!i_mode && i_run) m_busy = 1;
         else if (i_mode && i_run && m_prev == 0) begin
            m_busy = 1;
            m_cnt  = 0;
         end
      end
      m_pend = pnew;
      m_prev = int'(i_run);
      if (en == 1) m_sq = 1 - m_sq;
   endtask

   // Sample and compare, clock once, advance model; starts and ends at negedge.
   task automatic tick();
      #1;
      last_en  = int'(o_en);
      last_cnt = int'(o_cnt);
      chk("o_en", int'(o_en), m_en());
      chk("o_cnt", int'(o_cnt), m_cnt);
      chk("o_busy", int'(o_busy), m_busy);
      chk("o_div", int'(o_div), m_act);
`ifdef ENABLE_DIV_GEN_SQUARE_EN
      chk("o_sq", int'(o_sq), m_sq);
`endif
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic wait_en(input int limit, output int n);
      n = -1;
      for (int i = 1; i <= limit; i++) begin
         tick();
         if (last_en == 1) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic pulse_arst();
      i_arst = 1'b1;
      #1;
      model_reset();
      #1;
      i_arst = 1'b0;
   endtask

   typedef struct {
      logic       sclr, run, mode, load;
      logic [7:0] div;
      int         en, cnt, busy, dv;
   } vec_t;

   vec_t vt[11];

   initial begin
      int n, cnt_en, first;
      model_reset();
      // one-shot with divisor 3, retrigger, level ignored, then sync clear
      vt[0]  = '{0, 0, 1, 1, 8'd3, 0, 0, 0, 10};
      vt[1]  = '{0, 1, 1, 0, 8'd0, 0, 0, 0, 3};
      vt[2]  = '{0, 1, 1, 0, 8'd0, 0, 0, 1, 3};
      vt[3]  = '{0, 1, 1, 0, 8'd0, 0, 1, 1, 3};
      vt[4]  = '{0, 1, 1, 0, 8'd0, 1, 2, 1, 3};
      vt[5]  = '{0, 1, 1, 0, 8'd0, 0, 0, 0, 3};
      vt[6]  = '{0, 0, 1, 0, 8'd0, 0, 0, 0, 3};
      vt[7]  = '{0, 1, 1, 0, 8'd0, 0, 0, 0, 3};
      vt[8]  = '{0, 0, 1, 0, 8'd0, 0, 0, 1, 3};
      vt[9]  = '{1, 0, 1, 0, 8'd0, 0, 1, 1, 3};
      vt[10] = '{0, 0, 0, 0, 8'd0, 0, 0, 0, 3};

      // reset values
      @(negedge clk);
      #1;
      chk("rst_en", int'(o_en), 0);
      chk("rst_cnt", int'(o_cnt), 0);
      chk("rst_busy", int'(o_busy), 0);
      chk("rst_div", int'(o_div), 10);
      @(negedge clk);
      i_arst = 1'b0;

      for (int i = 0; i < 11; i++) begin
         i_sclr = vt[i].sclr; i_run = vt[i].run; i_mode = vt[i].mode;
         i_div_load = vt[i].load; i_div = vt[i].div;
         #1;
         chk($sformatf("vec%0d_en", i), int'(o_en), vt[i].en);
         chk($sformatf("vec%0d_cnt", i), int'(o_cnt), vt[i].cnt);
         chk($sformatf("vec%0d_busy", i), int'(o_busy), vt[i].busy);
         chk($sformatf("vec%0d_div", i), int'(o_div), vt[i].dv);
         tick();
      end
      i_sclr = 0; i_run = 0; i_mode = 0; i_div_load = 0;

      // continuous, divisor 10: first tick after 10 counts, then every 10
      i_div_load = 1; i_div = 8'd10;
      tick();
      i_div_load = 0; i_run = 1;
      tick();
      wait_en(30, n);
      chk("first_period", n, 10);
      wait_en(30, n);
      chk("period10", n, 10);

      // load 4 at count 3: current period still ends at 10, then period 4
      tick(); tick(); tick();
      i_div_load = 1; i_div = 8'd4;
      tick();
      chk("load_at_cnt", last_cnt, 3);
      i_div_load = 0;
      wait_en(30, n);
      chk("period_finish", n, 6);
      chk("div_after_wrap", int'(o_div), 4);
      wait_en(30, n);
      chk("period4", n, 4);

      // divisor 0 behaves as 1: enable every cycle, count pinned at 0
      i_div_load = 1; i_div = 8'd0;
      tick();
      i_div_load = 0;
      wait_en(30, n);
      chk("period_before_d1", n, 3);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("d0_en", last_en, 1);
         chk("d0_cnt", last_cnt, 0);
      end
      i_div_load = 1; i_div = 8'd1;
      tick();
      i_div_load = 0;
      tick();
      chk("d1_en", last_en, 1);
      chk("d1_div", int'(o_div), 1);

      // one-shot divisor 5, run held 20 cycles
      i_run = 0;
      tick();
      i_mode = 1; i_div_load = 1; i_div = 8'd5;
      tick();
      i_div_load = 0; i_run = 1;
      cnt_en = 0; first = -1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (last_en == 1) begin
            cnt_en++;
            if (first < 0) first = i;
         end
      end
      chk("oneshot_count", cnt_en, 1);
      chk("oneshot_first", first, 6);
      chk("oneshot_busy_after", int'(o_busy), 0);
      i_run = 0;
      tick();
      i_run = 1;
      wait_en(20, n);
      chk("oneshot_retrigger", n, 6);

      // async reset mid-period, then sync clear during run
      i_mode = 0; i_run = 0; i_div_load = 1; i_div = 8'd10;
      tick();
      i_div_load = 0; i_run = 1;
      for (int i = 0; i < 30 && o_cnt != 8'd6; i++) tick();
      chk("pre_arst_cnt", int'(o_cnt), 6);
      i_arst = 1'b1;
      #1;
      chk("arst_en", int'(o_en), 0);
      chk("arst_cnt", int'(o_cnt), 0);
      chk("arst_busy", int'(o_busy), 0);
      chk("arst_div", int'(o_div), 10);
      model_reset();
      #1;
      i_arst = 1'b0;
      wait_en(30, n);
      chk("post_arst_period", n, 11);
      tick(); tick();
      i_sclr = 1;
      tick();
      i_sclr = 0; i_run = 0;
      #1;
      chk("sclr_busy", int'(o_busy), 0);
      chk("sclr_cnt", int'(o_cnt), 0);
      @(negedge clk);

`ifdef ENABLE_DIV_GEN_SQUARE_EN
      begin
         int sq_hist[30];
         int bad, high;
         i_div_load = 1; i_div = 8'd3;
         tick();
         i_div_load = 0; i_run = 1;
         tick();
         for (int i = 0; i < 30; i++) begin
            #1;
            sq_hist[i] = int'(o_sq);
            #1;
            tick();
         end
         bad = 0; high = 0;
         for (int i = 0; i < 24; i++) begin
            if (sq_hist[i] == sq_hist[i + 3]) bad++;
            if (sq_hist[i] != sq_hist[i + 6]) bad++;
         end
         for (int i = 0; i < 12; i++) high += sq_hist[i];
         chk("sq_period_violations", bad, 0);
         chk("sq_duty_high_of_12", high, 6);
         i_run = 0;
         tick();
      end
`endif

      // randomized run against the model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) pulse_arst();
         i_sclr     = ($urandom_range(0, 63) == 0);
         i_run      = ($urandom_range(0, 3) != 0);
         i_mode     = ($urandom_range(0, 1) == 1);
         i_div_load = ($urandom_range(0, 7) == 0);
         i_div      = ($urandom_range(0, 9) == 0) ? W'($urandom_range(0, 255))
                                                  : W'($urandom_range(0, 12));
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
